apb_master_nslv: RTL and testbench

- Parametrised APB4 master bridging the CPU-side internal request interface to NUM_SLV memory-mapped peripherals.
- Adds the following over the fixed 6-slave master:
  - generic slave count and region size,
  - PSTRB and PSLVERR support,
  - an error response for unmapped addresses,
  - a PREADY timeout watchdog,
  - registered completion outputs.
- Sits between the RISC-V core's data bus and the peripheral set (GPIO, UART, timers, ...).

---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_addr_decoder.sv | 38 +++
 rtl/apb_master_nslv.sv | 204 ++++++++++++++++++++
 tb/tb_apb_master_nslv.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the parametrised APB4 master and its address decoder.
package apb_pkg;

  // Transfer sequencing states of the master.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Default peripheral window: slave 0 starts here, each slave owns 4 KiB.
  localparam logic [31:0] APB_BASE_ADDR_DEF     = 32'h1000_0000;
  localparam int          APB_SLV_SIZE_LOG2_DEF = 12;

  // Widest configuration the read-data slicer supports (16 slaves x 128 bits).
  localparam int APB_MAX_SLV    = 16;
  localparam int APB_DATA_MAX_W = 128;
  localparam int APB_BUS_MAX_W  = APB_MAX_SLV * APB_DATA_MAX_W;

  // Extract slave idx's read word from the flattened PRDATA bus. The caller
  // zero-extends the bus to APB_BUS_MAX_W and truncates the result to its own
  // DATA_W, so one function serves every parameterisation.
  function automatic logic [APB_DATA_MAX_W-1:0] apb_prdata_slice(
    input logic [APB_BUS_MAX_W-1:0] bus,
    input int unsigned              idx,
    input int unsigned              data_w
  );
    return APB_DATA_MAX_W'(bus >> (idx * data_w));
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps an address onto one of NUM_SLV equally
// sized regions starting at BASE_ADDR and flags addresses outside the window.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLV       = 6,
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(APB_BASE_ADDR_DEF),
  parameter int                SLV_SIZE_LOG2 = APB_SLV_SIZE_LOG2_DEF,
  localparam int               IDX_W         = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [NUM_SLV-1:0] o_sel,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_mapped
);

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_idx_full;
  logic              w_above_base;

  // The full-width region index is kept so addresses past the last slave are
  // recognised instead of aliasing onto a low index after truncation.
  assign w_above_base = (i_addr >= BASE_ADDR);
  assign w_off        = i_addr - BASE_ADDR;
  assign w_idx_full   = w_off >> SLV_SIZE_LOG2;
  assign o_mapped     = w_above_base && (w_idx_full < ADDR_W'(NUM_SLV));
  assign o_idx        = IDX_W'(w_idx_full);

  // One-hot select, all-zero for unmapped addresses.
  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      o_sel[i] = o_mapped && (w_idx_full == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/apb_master_nslv.sv
// APB4 master bridging the core's internal request strobe interface to
// NUM_SLV peripherals, with byte strobes, slave error, unmapped-address error,
// a PREADY watchdog and registered completion outputs.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int                NUM_SLV       = 6,
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(APB_BASE_ADDR_DEF),
  parameter int                SLV_SIZE_LOG2 = APB_SLV_SIZE_LOG2_DEF,
  parameter int                TIMEOUT       = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  // APB side
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  // Requester side
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      busy,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      error
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  apb_state_e r_state;
  apb_state_e w_state_nxt;

  // Latched request and its decode, stable from SETUP to completion.
  logic [ADDR_W-1:0]  r_paddr;
  logic               r_pwrite;
  logic [DATA_W-1:0]  r_pwdata;
  logic [STRB_W-1:0]  r_pstrb;
  logic [NUM_SLV-1:0] r_sel;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mapped;

  logic [CNT_W-1:0]   r_wait_cnt;

  logic               r_ready;
  logic               r_error;
  logic [DATA_W-1:0]  r_rdata;

  logic [NUM_SLV-1:0] w_dec_sel;
  logic [IDX_W-1:0]   w_dec_idx;
  logic               w_dec_mapped;
  logic               w_accept;
  logic               w_pready_sel;
  logic               w_pslverr_sel;
  logic [DATA_W-1:0]  w_prdata_sel;
  logic               w_timeout;
  logic               w_done;

  apb_addr_decoder #(
    .NUM_SLV       (NUM_SLV),
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
  ) u_decoder (
    .i_addr   (addr),
    .o_sel    (w_dec_sel),
    .o_idx    (w_dec_idx),
    .o_mapped (w_dec_mapped)
  );

  assign w_accept = (r_state == IDLE) && transfer;

  // Responses from non-selected slaves are masked out by the latched one-hot
  // select; an unmapped access has an all-zero select and never sees PREADY.
  assign w_pready_sel  = |(PREADY & r_sel);
  assign w_pslverr_sel = |(PSLVERR & r_sel);
  assign w_prdata_sel  = DATA_W'(apb_prdata_slice(APB_BUS_MAX_W'(PRDATA),
                                                  32'(r_idx), DATA_W));

  // The watchdog fires in the ACCESS cycle whose count is TIMEOUT-1, so a
  // stuck slave sees exactly TIMEOUT ACCESS cycles.
  assign w_timeout = (TIMEOUT > 0) && !w_pready_sel &&
                     (r_wait_cnt == CNT_W'(TO_LAST));
  assign w_done    = !r_mapped || w_pready_sel || w_timeout;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> SETUP on a request, SETUP -> ACCESS always,
  // ACCESS -> IDLE on ready, unmapped address or watchdog expiry.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // variable unassigned and infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (transfer) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // APB control outputs decoded from the state alone, so an asynchronous
  // reset drops PSEL and PENABLE in the same cycle it is asserted.
  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    busy    = 1'b0;
    case (r_state)
      SETUP: begin
        PSEL = r_sel;
        busy = 1'b1;
      end
      ACCESS: begin
        PSEL    = r_sel;
        PENABLE = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the request and its decode when it is accepted in IDLE; reads
  // carry an all-zero strobe.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_sel    <= '0;
      r_idx    <= '0;
      r_mapped <= 1'b0;
    end else if (w_accept) begin
      r_paddr  <= addr;
      r_pwrite <= write;
      r_pwdata <= wdata;
      r_pstrb  <= write ? wstrb : '0;
      r_sel    <= w_dec_sel;
      r_idx    <= w_dec_idx;
      r_mapped <= w_dec_mapped;
    end
  end

  // Watchdog counter: cleared in SETUP, advanced for each ACCESS wait cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !w_pready_sel) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Registered completion: one-cycle ready pulse with error and read data.
  // Unmapped and timed-out accesses return error with zero data; a write keeps
  // the previous read data.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b0;
      if ((r_state == ACCESS) && w_done) begin
        r_ready <= 1'b1;
        if (!r_mapped || w_timeout) begin
          r_error <= 1'b1;
          r_rdata <= '0;
        end else begin
          r_error <= w_pslverr_sel;
          if (!r_pwrite) r_rdata <= w_prdata_sel;
        end
      end
    end
  end

  assign PADDR  = r_paddr;
  assign PWRITE = r_pwrite;
  assign PWDATA = r_pwdata;
  assign PSTRB  = r_pstrb;
  assign ready  = r_ready;
  assign error  = r_error;
  assign rdata  = r_rdata;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Directed bench for apb_master_nslv (6 slaves, 32-bit, 4 KiB regions,
// TIMEOUT=16). Expected responses are queued when a transfer is issued and
// compared when the ready pulse appears.
module tb_apb_master_nslv;

  localparam int NUM_SLV = 6;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;

  logic                      PCLK;
  logic                      PRESET;
  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic                      PENABLE;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;
  logic                      transfer;
  logic                      write;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wdata;
  logic [STRB_W-1:0]         wstrb;
  logic                      busy;
  logic                      ready;
  logic [DATA_W-1:0]         rdata;
  logic                      error;

  apb_master_nslv #(
    .NUM_SLV       (NUM_SLV),
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .BASE_ADDR     (32'h1000_0000),
    .SLV_SIZE_LOG2 (12),
    .TIMEOUT       (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .busy     (busy),
    .ready    (ready),
    .rdata    (rdata),
    .error    (error)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks       = 0;
  int   failures     = 0;
  int   cyc          = 0;
  int   last_start   = 0;
  int   sb_pushed    = 0;
  int   ready_pulses = 0;

  // Independent count of every cycle in which ready is high.
  always @(negedge PCLK) if (ready === 1'b1) ready_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    cyc++;
  endtask

  task automatic sb_push(input logic err, input logic [31:0] rd, input int lat);
    exp_t e;
    e.err = err; e.rdata = rd; e.lat = lat;
    sb_q.push_back(e);
    sb_pushed++;
  endtask

  // Present a request in an IDLE cycle; returns in the SETUP cycle.
  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    transfer = 1'b1; write = w; addr = a; wdata = d; wstrb = s;
    last_start = cyc;
    tick();
    transfer = 1'b0;
  endtask

  // Wait (bounded) for the ready pulse and compare it with the scoreboard.
  task automatic wait_ready(input string tag);
    exp_t e;
    int   n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, ready, 1'b1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_error"}, error, e.err);
      check({tag, "_rdata"}, rdata, e.rdata);
      check({tag, "_latency"}, 64'(cyc - last_start), 64'(e.lat));
    end
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] unm [3];

    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    PREADY = '1; PSLVERR = '0;
    for (int i = 0; i < NUM_SLV; i++) PRDATA[i*DATA_W +: DATA_W] = 32'hA0A0_0000 | 32'(i);
    #2;
    // Reset state
    check("rst_psel", PSEL, 6'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_paddr_pwdata", {PADDR, PWDATA}, 64'd0);
    check("rst_pstrb_pwrite", {PSTRB, PWRITE}, 5'd0);
    check("rst_ready_err_busy", {ready, error, busy}, 3'd0);
    check("rst_rdata", rdata, 32'd0);
    tick(); tick();
    PRESET = 1'b0;
    tick();

    // 1: write to slave 2, ready in first ACCESS
    sb_push(1'b0, 32'h0, 3);
    start(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 4'hF);
    check("t1_setup_psel", PSEL, 6'b000100);
    check("t1_setup_penable", PENABLE, 1'b0);
    check("t1_setup_busy", busy, 1'b1);
    check("t1_pstrb", PSTRB, 4'hF);
    check("t1_paddr_pwdata", {PADDR, PWDATA}, {32'h1000_2004, 32'hDEAD_BEEF});
    check("t1_pwrite", PWRITE, 1'b1);
    tick();
    check("t1_access_penable", PENABLE, 1'b1);
    check("t1_access_psel", PSEL, 6'b000100);
    wait_ready("t1");
    tick();
    check("t1_ready_one_cycle", ready, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // 2: read slave 5 with two wait cycles; other slaves' PREADY/PSLVERR ignored
    PREADY = 6'b011111; PSLVERR = 6'b011111;
    PRDATA[5*DATA_W +: DATA_W] = 32'h1234_5678;
    sb_push(1'b0, 32'h1234_5678, 5);
    start(1'b0, 32'h1000_5000, 32'hFFFF_FFFF, 4'hF);
    check("t2_setup_psel", PSEL, 6'b100000);
    check("t2_pstrb_read", PSTRB, 4'h0);
    check("t2_pwrite", PWRITE, 1'b0);
    tick();
    tick();
    check("t2_wait_penable", PENABLE, 1'b1);
    check("t2_wait_paddr", PADDR, 32'h1000_5000);
    check("t2_wait_ready_low", ready, 1'b0);
    tick();
    PREADY = '1;
    wait_ready("t2");
    tick();

    // 3: unmapped addresses (outside window, first index past the last slave, below base)
    PREADY = '0; PSLVERR = '0;
    unm[0] = 32'h2000_0000; unm[1] = 32'h1000_6000; unm[2] = 32'h0FFF_FFFC;
    for (int k = 0; k < 3; k++) begin
      sb_push(1'b1, 32'h0, 3);
      start(1'b0, unm[k], 32'h0, 4'h0);
      check($sformatf("t3_%0d_setup_psel", k), PSEL, 6'b0);
      tick();
      check($sformatf("t3_%0d_access_psel", k), PSEL, 6'b0);
      check($sformatf("t3_%0d_access_penable", k), PENABLE, 1'b1);
      wait_ready($sformatf("t3_%0d", k));
      tick();
    end

    // 5: write with PSLVERR, then a read accepted on the ready cycle
    PREADY = '1; PSLVERR = 6'b001000;
    PRDATA[0 +: DATA_W] = 32'h0BAD_F00D;
    sb_push(1'b1, 32'h0, 3);
    start(1'b1, 32'h1000_3008, 32'h55AA_1234, 4'b0110);
    check("t5_setup_psel", PSEL, 6'b001000);
    check("t5_pstrb", PSTRB, 4'b0110);
    wait_ready("t5w");
    sb_push(1'b0, 32'h0BAD_F00D, 3);
    start(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    check("t5_b2b_setup_psel", PSEL, 6'b000001);
    check("t5_b2b_setup_penable", PENABLE, 1'b0);
    check("t5_b2b_busy", busy, 1'b1);
    wait_ready("t5r");
    tick();

    // 4: PREADY1 stuck low -> watchdog abort after 16 ACCESS cycles
    PREADY = '0; PSLVERR = '0;
    sb_push(1'b1, 32'h0, 18);
    start(1'b0, 32'h1000_1000, 32'h0, 4'h0);
    check("t4_setup_psel", PSEL, 6'b000010);
    tick();
    n = 0;
    while (PENABLE === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("t4_access_cycles", 64'(n), 64'd16);
    check("t4_penable_after", PENABLE, 1'b0);
    wait_ready("t4");
    tick();

    // 6: reset asserted during ACCESS
    PREADY = '0;
    start(1'b0, 32'h1000_4000, 32'h0, 4'h0);
    tick();
    check("t6_access_psel", PSEL, 6'b010000);
    check("t6_access_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    #1;
    check("t6_async_psel", PSEL, 6'b0);
    check("t6_async_penable", PENABLE, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    tick(); tick();
    PRESET = 1'b0;
    check("t6_post_rst_rdata_err", {rdata, error}, 33'd0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ready !== 1'b0) seen = 1'b1;
      tick();
    end
    check("t6_no_ready_after_abort", seen, 1'b0);
    PREADY = '1;
    sb_push(1'b0, 32'h0, 3);
    start(1'b1, 32'h1000_4000, 32'h600D_600D, 4'hF);
    check("t6_resume_psel", PSEL, 6'b010000);
    wait_ready("t6");
    tick(); tick();

    // Every ready pulse matches exactly one queued completion
    check("ready_pulse_count", 64'(ready_pulses), 64'(sb_pushed));
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
